approx_err_monitor: RTL and testbench
=====================================

// Module: approx_err_monitor
// PURPOSE
//  Synthesizable, parametrised error-metric accumulator for approximate adders.
//  Streams (exact, approximate) sum pairs over a run of num_samples.
//  Accumulates error count, sum of error distances, max error distance and exact-zero count.
//  Host/firmware derives ER, MED, NMED and MRED-valid count from these outputs.
//  Sits beside any approximate adder instance (N-bit sum) for on-silicon or emulation characterisation.
// PARAMETERS
//  N      16  operand/sum width, compared modulo 2^N
//  CNT_W  32  width of the sample, error and zero counters
//  ACC_W  48  width of the error-distance accumulator; must be >= N
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      one-cycle pulse; launches a run (accepted in IDLE/DONE only)
//  num_samples  in   CNT_W  samples per run; latched on accepted start
//  in_valid     in   1      exact_s/approx_s valid
//  in_ready     out  1      block can accept a pair this cycle
//  exact_s      in   N      exact reference sum
//  approx_s     in   N      approximate adder sum
//  busy         out  1      state is RUN or DRAIN
//  done         out  1      high in DONE; results stable
//  sample_count out  CNT_W  pairs accumulated
//  err_count    out  CNT_W  pairs with approx_s != exact_s
//  zero_count   out  CNT_W  pairs with exact_s == 0 (excluded from MRED)
//  sum_ed       out  ACC_W  sum of |approx_s - exact_s|
//  max_ed       out  N      largest |approx_s - exact_s| seen
//  acc_ovf      out  1      sticky; sum_ed saturated
//  bias_sum     out  ACC_W  signed sum of (approx_s - exact_s); ERR_BIAS_EN only
// BEHAVIOUR
//  Reset: state IDLE; in_ready, busy, done, acc_ovf = 0; all counters, sums and max_ed = 0.
//  Transfer: a pair is accepted on a clk edge with in_valid && in_ready.
//  in_ready = (state==RUN) && (accepted < num_samples_latched).
//  Pipeline stage 1 registers ed = |approx_s - exact_s| as an N-bit unsigned magnitude.
//    Stage 1 also registers mismatch and exact_zero flags.
//  Stage 2 updates all accumulators. Outputs reflect a pair 2 cycles after acceptance.
//  States:
//    IDLE  -> RUN    on start with num_samples != 0. Clears all accumulators, acc_ovf and the internal accept count.
//    IDLE  -> DONE   on start with num_samples == 0. Clears all; results zero.
//    RUN   -> DRAIN  on acceptance of the last pair.
//    DRAIN -> DONE   after 2 cycles, once the pipeline has flushed.
//    DONE  -> RUN/DONE  on start, same rules as IDLE; accumulators are cleared.
//  start while busy is ignored: no restart, no clear.
//  in_valid outside RUN is ignored and never accepted.
//  max_ed updates when ed > max_ed. Ties keep the old value.
//  sum_ed saturates at 2^ACC_W-1. Saturation sets acc_ovf, which stays set until next start.
//  Counters are CNT_W wide and cannot overflow: accepted count is <= num_samples.
//  Reset mid-run: immediate return to reset values. No partial results are retained.
// CONFIGURATION
//  ERR_BIAS_EN defined:
//    Stage 1 also registers the signed N+1-bit diff = approx_s - exact_s.
//    bias_sum accumulates diff, sign-extended to ACC_W, in two's complement and wraps.
//    bias_sum is cleared on start and reset.
//  ERR_BIAS_EN undefined: bias_sum port and logic are absent.
// TESTING
//  T1 reset: assert rst_n=0 mid-RUN -> all outputs 0 on the next sample, state IDLE, in_ready=0.
//  T2 exact: num_samples=4, approx_s==exact_s for 4 pairs, in_valid held
//     -> in_ready=1 for 4 cycles then 0; done 2 cycles after the 4th accept.
//     Final: sample_count=4, err_count=0, sum_ed=0, max_ed=0.
//  T3 mixed, num_samples=3, pairs (exact,approx) = (100,96), (0,0), (50,57)
//     -> err_count=2, zero_count=1, sum_ed=11, max_ed=7.
//     With ERR_BIAS_EN: bias_sum=3.
//  T4 backpressure: num_samples=5, in_valid toggled randomly
//     -> exactly 5 accepts; sample_count=5; extra in_valid after the 5th is not accepted.
//  T5 edge runs:
//     num_samples=0 -> done on the cycle after start, all results 0.
//     start pulsed during RUN -> ignored; run completes with the original count.
//  T6 saturation: ACC_W=16, N=16, pairs (0,0xFFFF) x2
//     -> sum_ed=0xFFFF, acc_ovf=1, max_ed=0xFFFF; the next start clears acc_ovf.

Source files
------------

// File: rtl/approx_err_monitor.sv
// ----------------------------------------------------------------------------
// approx_err_monitor
//
// Purpose:
//   Error-metric accumulator for characterising an approximate adder. It
//   streams (exact, approximate) N-bit sum pairs over a run of num_samples.
//   Over that run it accumulates:
//     - the sample count
//     - the error count (pairs that differ)
//     - the exact-zero count (pairs excluded from MRED)
//     - the sum of error distances |approx - exact|, which saturates
//     - the largest error distance seen
//   Host firmware derives ER, MED, NMED and the MRED-valid count from these
//   results.
//
// Optional feature:
//   Define ERR_BIAS_EN to add o_bias_sum. It is a wrapping two's-complement
//   sum of the signed difference (approx - exact).
//
// Parameters:
//   N      operand/sum width
//   CNT_W  width of the sample/error/zero counters
//   ACC_W  width of the error-distance accumulator (>= N)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   i_start         one-cycle pulse; launches a run (IDLE/DONE only)
//   i_num_samples   samples per run, latched on an accepted start
//   i_in_valid      i_exact_s / i_approx_s valid
//   o_in_ready      block accepts a pair this cycle
//   i_exact_s       exact reference sum
//   i_approx_s      approximate adder sum
//   o_busy          run in progress (RUN or DRAIN)
//   o_done          results final and stable
//   o_sample_count  pairs accumulated
//   o_err_count     pairs with approx != exact
//   o_zero_count    pairs with exact == 0
//   o_sum_ed        saturating sum of |approx - exact|
//   o_max_ed        largest |approx - exact|
//   o_acc_ovf       sticky: o_sum_ed saturated
//   o_bias_sum      signed sum of (approx - exact)   [ERR_BIAS_EN only]
// ----------------------------------------------------------------------------
module approx_err_monitor #(
    parameter int N     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_samples,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [N-1:0]     i_exact_s,
    input  logic [N-1:0]     i_approx_s,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_sample_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_zero_count,
    output logic [ACC_W-1:0] o_sum_ed,
    output logic [N-1:0]     o_max_ed,
    output logic             o_acc_ovf
`ifdef ERR_BIAS_EN
    ,
    output logic [ACC_W-1:0] o_bias_sum
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [CNT_W-1:0] r_num_samples;
    logic [CNT_W-1:0] r_accepted;
    logic             r_drain_cnt;

    logic             w_start_ok;
    logic             w_accept;
    logic             w_last;

    logic             w_neg;
    logic [N-1:0]     w_ed;

    logic             r_s1_valid;
    logic [N-1:0]     r_s1_ed;
    logic             r_s1_mis;
    logic             r_s1_zero;

    logic [CNT_W-1:0] r_sample_count;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_zero_count;
    logic [ACC_W-1:0] r_sum_ed;
    logic [N-1:0]     r_max_ed;
    logic             r_acc_ovf;
    logic [ACC_W:0]   w_sum_wide;

`ifdef ERR_BIAS_EN
    logic signed [N:0]     w_diff;
    logic signed [N:0]     r_s1_diff;
    logic [ACC_W-1:0]      r_bias_sum;
`endif

    // Start is honoured only between runs; a start while busy changes nothing.
    assign w_start_ok = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign o_in_ready = (r_state == ST_RUN) && (r_accepted < r_num_samples);
    assign w_accept   = i_in_valid && o_in_ready;
    // The last pair is the one that brings the accept count up to the target.
    assign w_last     = w_accept && (r_accepted == (r_num_samples - CNT_W'(1)));

    // Error distance magnitude without a wider subtractor: pick the
    // subtraction order from the comparison so the result never wraps.
    assign w_neg = (i_approx_s < i_exact_s);
    assign w_ed  = w_neg ? (i_exact_s - i_approx_s) : (i_approx_s - i_exact_s);

`ifdef ERR_BIAS_EN
    assign w_diff = $signed({1'b0, i_approx_s}) - $signed({1'b0, i_exact_s});
`endif

    // State register plus the small run bookkeeping (target, accept count,
    // and the drain timer that lets the two pipeline stages empty).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_num_samples <= '0;
            r_accepted    <= '0;
            r_drain_cnt   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= (r_state == ST_DRAIN);
            if (w_start_ok) begin
                r_num_samples <= i_num_samples;
                r_accepted    <= '0;
            end else if (w_accept) begin
                r_accepted <= r_accepted + CNT_W'(1);
            end
        end
    end

    // Next-state logic. DRAIN lasts two cycles: the first covers stage 1,
    // the second covers stage 2, so DONE is only reached with final results.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_next_state = (i_num_samples != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Stage 1 captures the per-pair metrics of an accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_ed    <= '0;
            r_s1_mis   <= 1'b0;
            r_s1_zero  <= 1'b0;
`ifdef ERR_BIAS_EN
            r_s1_diff  <= '0;
`endif
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_ed   <= w_ed;
                r_s1_mis  <= (i_approx_s != i_exact_s);
                r_s1_zero <= (i_exact_s == '0);
`ifdef ERR_BIAS_EN
                r_s1_diff <= w_diff;
`endif
            end
        end
    end

    // One extra bit on the distance sum exposes the carry that triggers
    // saturation.
    assign w_sum_wide = (ACC_W + 1)'(r_sum_ed) + (ACC_W + 1)'(r_s1_ed);

    // Stage 2 folds stage-1 results into the accumulators. An accepted
    // start wipes every result so each run starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_zero_count   <= '0;
            r_sum_ed       <= '0;
            r_max_ed       <= '0;
            r_acc_ovf      <= 1'b0;
`ifdef ERR_BIAS_EN
            r_bias_sum     <= '0;
`endif
        end else if (w_start_ok) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_zero_count   <= '0;
            r_sum_ed       <= '0;
            r_max_ed       <= '0;
            r_acc_ovf      <= 1'b0;
`ifdef ERR_BIAS_EN
            r_bias_sum     <= '0;
`endif
        end else if (r_s1_valid) begin
            r_sample_count <= r_sample_count + CNT_W'(1);
            r_err_count    <= r_err_count + CNT_W'(r_s1_mis);
            r_zero_count   <= r_zero_count + CNT_W'(r_s1_zero);
            if (w_sum_wide[ACC_W]) begin
                r_sum_ed  <= '1;
                r_acc_ovf <= 1'b1;
            end else begin
                r_sum_ed <= w_sum_wide[ACC_W-1:0];
            end
            if (r_s1_ed > r_max_ed) begin
                r_max_ed <= r_s1_ed;
            end
`ifdef ERR_BIAS_EN
            r_bias_sum <= r_bias_sum + ACC_W'(r_s1_diff);
`endif
        end
    end

    assign o_busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done         = (r_state == ST_DONE);
    assign o_sample_count = r_sample_count;
    assign o_err_count    = r_err_count;
    assign o_zero_count   = r_zero_count;
    assign o_sum_ed       = r_sum_ed;
    assign o_max_ed       = r_max_ed;
    assign o_acc_ovf      = r_acc_ovf;
`ifdef ERR_BIAS_EN
    assign o_bias_sum     = r_bias_sum;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// ----------------------------------------------------------------------------
// tb_approx_err_monitor
//
// Purpose:
//   Self-checking bench for approx_err_monitor. It uses two instances:
//     - a default-parameter instance for the functional runs
//     - an ACC_W=16 instance for saturation of the distance sum
//   Expected results come from fixed constants or from a reference model that
//   works on whole runs with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_approx_err_monitor;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [31:0] numSamples;
    logic        inValid;
    logic        inReady;
    logic [15:0] exactS;
    logic [15:0] approxS;
    logic        busy;
    logic        done;
    logic [31:0] sampleCount;
    logic [31:0] errCount;
    logic [31:0] zeroCount;
    logic [47:0] sumEd;
    logic [15:0] maxEd;
    logic        accOvf;
    logic [47:0] biasSum;

    logic        sStart;
    logic [31:0] sNumSamples;
    logic        sInValid;
    logic        sInReady;
    logic [15:0] sExactS;
    logic [15:0] sApproxS;
    logic        sBusy;
    logic        sDone;
    logic [31:0] sSampleCount;
    logic [31:0] sErrCount;
    logic [31:0] sZeroCount;
    logic [15:0] sSumEd;
    logic [15:0] sMaxEd;
    logic        sAccOvf;
    logic [15:0] sBiasSum;

    int compared;
    int mismatched;

    logic [15:0] qEx[$];
    logic [15:0] qAp[$];

    typedef struct {
        logic [15:0] ex;
        logic [15:0] ap;
        int          expErr;
        int          expZero;
        longint      expEd;
        longint      expBias;
    } vec_t;

    vec_t vecs[6];

    approx_err_monitor #(.N(16), .CNT_W(32), .ACC_W(48)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_num_samples  (numSamples),
        .i_in_valid     (inValid),
        .o_in_ready     (inReady),
        .i_exact_s      (exactS),
        .i_approx_s     (approxS),
        .o_busy         (busy),
        .o_done         (done),
        .o_sample_count (sampleCount),
        .o_err_count    (errCount),
        .o_zero_count   (zeroCount),
        .o_sum_ed       (sumEd),
        .o_max_ed       (maxEd),
        .o_acc_ovf      (accOvf)
`ifdef ERR_BIAS_EN
        ,
        .o_bias_sum     (biasSum)
`endif
    );

    approx_err_monitor #(.N(16), .CNT_W(32), .ACC_W(16)) dutSat (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (sStart),
        .i_num_samples  (sNumSamples),
        .i_in_valid     (sInValid),
        .o_in_ready     (sInReady),
        .i_exact_s      (sExactS),
        .i_approx_s     (sApproxS),
        .o_busy         (sBusy),
        .o_done         (sDone),
        .o_sample_count (sSampleCount),
        .o_err_count    (sErrCount),
        .o_zero_count   (sZeroCount),
        .o_sum_ed       (sSumEd),
        .o_max_ed       (sMaxEd),
        .o_acc_ovf      (sAccOvf)
`ifdef ERR_BIAS_EN
        ,
        .o_bias_sum     (sBiasSum)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input longint unsigned act,
                               input longint unsigned exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch a run of n pairs taken from qEx/qAp.
    // in_valid is asserted with probability validPct. injectStart fires a
    // spurious start (with a different count) while the run is busy.
    // After the last accept, in_valid stays high to prove nothing more is taken.
    task automatic applyStimulus(input int n, input int validPct, input bit injectStart);
        int idx;
        int budget;
        bit acc;
        idx = 0;
        budget = 0;
        numSamples = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < n && budget < 400) begin
            inValid = ($urandom_range(99) < validPct);
            exactS  = qEx[idx];
            approxS = qAp[idx];
            if (injectStart && idx == 1) begin
                start      = 1'b1;
                numSamples = n + 5;
            end else begin
                start = 1'b0;
            end
            acc = inValid && inReady;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        start = 1'b0;
        checkOutput("accepted_pairs", idx, n);
        inValid = 1'b1;
        checkOutput("ready_after_last", inReady, 0);
        budget = 0;
        while (!done && budget < 20) begin
            @(posedge clk); #1;
            checkOutput("ready_in_drain", inReady, 0);
            budget++;
        end
        checkOutput("done_reached", done, 1);
        inValid = 1'b0;
    endtask

    // Reference model over the first n queued pairs, compared with the final
    // results.
    task automatic checkRun(input string tag, input int n);
        longint expSum;
        longint expBias;
        int     expErr;
        int     expZero;
        int     expMax;
        int     d;
        expSum = 0; expBias = 0; expErr = 0; expZero = 0; expMax = 0;
        for (int i = 0; i < n; i++) begin
            d = int'(qAp[i]) - int'(qEx[i]);
            expBias += d;
            if (d < 0) d = -d;
            expSum += d;
            if (d != 0) expErr++;
            if (qEx[i] == 16'd0) expZero++;
            if (d > expMax) expMax = d;
        end
        checkOutput({tag, "_samples"}, sampleCount, n);
        checkOutput({tag, "_err"}, errCount, expErr);
        checkOutput({tag, "_zero"}, zeroCount, expZero);
        checkOutput({tag, "_sum_ed"}, sumEd, expSum);
        checkOutput({tag, "_max_ed"}, maxEd, expMax);
        checkOutput({tag, "_ovf"}, accOvf, 0);
        checkOutput({tag, "_busy"}, busy, 0);
`ifdef ERR_BIAS_EN
        checkOutput({tag, "_bias"}, biasSum, longint'(expBias) & 64'h0000_FFFF_FFFF_FFFF);
`endif
    endtask

    initial begin
        int budget;
        logic [15:0] e;
        compared = 0;
        mismatched = 0;

        vecs[0] = '{16'd5,      16'd5,      0, 0, 0,       0};
        vecs[1] = '{16'd0,      16'd0,      0, 1, 0,       0};
        vecs[2] = '{16'd0,      16'hFFFF,   1, 1, 65535,   65535};
        vecs[3] = '{16'hFFFF,   16'd0,      1, 0, 65535,   -65535};
        vecs[4] = '{16'd100,    16'd96,     1, 0, 4,       -4};
        vecs[5] = '{16'd1234,   16'd1300,   1, 0, 66,      66};

        rst_n = 1'b0;
        start = 1'b0; numSamples = '0; inValid = 1'b0; exactS = '0; approxS = '0;
        sStart = 1'b0; sNumSamples = '0; sInValid = 1'b0; sExactS = '0; sApproxS = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", inReady, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sum_ed", sumEd, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-pair runs from the vector table.
        for (int v = 0; v < 6; v++) begin
            qEx.delete(); qAp.delete();
            qEx.push_back(vecs[v].ex);
            qAp.push_back(vecs[v].ap);
            applyStimulus(1, 100, 1'b0);
            checkOutput($sformatf("vec%0d_err", v), errCount, vecs[v].expErr);
            checkOutput($sformatf("vec%0d_zero", v), zeroCount, vecs[v].expZero);
            checkOutput($sformatf("vec%0d_sum_ed", v), sumEd, vecs[v].expEd);
            checkOutput($sformatf("vec%0d_max_ed", v), maxEd, vecs[v].expEd);
`ifdef ERR_BIAS_EN
            checkOutput($sformatf("vec%0d_bias", v), biasSum,
                        longint'(vecs[v].expBias) & 64'h0000_FFFF_FFFF_FFFF);
`endif
        end

        // Exact pairs with in_valid held: ready for 4 cycles, done 2 cycles later.
        numSamples = 4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exactS = 16'(i * 77 + 3);
            approxS = 16'(i * 77 + 3);
            checkOutput($sformatf("t2_ready%0d", i), inReady, 1);
            @(posedge clk); #1;
        end
        checkOutput("t2_ready_end", inReady, 0);
        checkOutput("t2_done_p0", done, 0);
        @(posedge clk); #1;
        checkOutput("t2_done_p1", done, 0);
        @(posedge clk); #1;
        checkOutput("t2_done_p2", done, 1);
        inValid = 1'b0;
        checkOutput("t2_samples", sampleCount, 4);
        checkOutput("t2_err", errCount, 0);
        checkOutput("t2_sum_ed", sumEd, 0);
        checkOutput("t2_max_ed", maxEd, 0);

        // Mixed three-pair run with known results.
        qEx = '{16'd100, 16'd0, 16'd50};
        qAp = '{16'd96, 16'd0, 16'd57};
        applyStimulus(3, 100, 1'b0);
        checkOutput("t3_err", errCount, 2);
        checkOutput("t3_zero", zeroCount, 1);
        checkOutput("t3_sum_ed", sumEd, 11);
        checkOutput("t3_max_ed", maxEd, 7);
`ifdef ERR_BIAS_EN
        checkOutput("t3_bias", biasSum, 3);
`endif

        // Backpressure: random in_valid over five pairs.
        qEx.delete(); qAp.delete();
        for (int i = 0; i < 5; i++) begin
            e = 16'($urandom);
            qEx.push_back(e);
            qAp.push_back(e ^ 16'($urandom_range(3)));
        end
        applyStimulus(5, 40, 1'b0);
        checkRun("t4", 5);

        // Zero-length run: done on the cycle after start, everything cleared.
        applyStimulus(0, 100, 1'b0);
        checkOutput("t5_zero_samples", sampleCount, 0);
        checkOutput("t5_zero_err", errCount, 0);
        checkOutput("t5_zero_sum", sumEd, 0);
        checkOutput("t5_zero_max", maxEd, 0);

        // Start pulsed during a run is ignored.
        qEx = '{16'd9, 16'd20, 16'd0};
        qAp = '{16'd1, 16'd20, 16'd3};
        applyStimulus(3, 100, 1'b1);
        checkRun("t5_inject", 3);

        // Randomised runs against the reference model.
        for (int r = 0; r < 15; r++) begin
            int n;
            n = $urandom_range(12, 1);
            qEx.delete(); qAp.delete();
            for (int i = 0; i < n; i++) begin
                e = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
                qEx.push_back(e);
                case ($urandom_range(3))
                    0: qAp.push_back(e);
                    1: qAp.push_back(e + 16'($urandom_range(40)));
                    2: qAp.push_back(e - 16'($urandom_range(40)));
                    default: qAp.push_back(16'($urandom));
                endcase
            end
            applyStimulus(n, 75, 1'b0);
            checkRun($sformatf("rand%0d", r), n);
        end

        // Reset in the middle of a run returns everything to zero at once.
        numSamples = 4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        inValid = 1'b1; exactS = 16'd10; approxS = 16'd3;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("t1_samples", sampleCount, 0);
        checkOutput("t1_err", errCount, 0);
        checkOutput("t1_sum_ed", sumEd, 0);
        checkOutput("t1_max_ed", maxEd, 0);
        checkOutput("t1_ready", inReady, 0);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_done", done, 0);
        inValid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Saturation on the ACC_W=16 instance.
        sNumSamples = 2; sStart = 1'b1;
        @(posedge clk); #1;
        sStart = 1'b0;
        sInValid = 1'b1; sExactS = 16'd0; sApproxS = 16'hFFFF;
        budget = 0;
        while (!sDone && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        sInValid = 1'b0;
        checkOutput("t6_done", sDone, 1);
        checkOutput("t6_samples", sSampleCount, 2);
        checkOutput("t6_sum_ed", sSumEd, 16'hFFFF);
        checkOutput("t6_ovf", sAccOvf, 1);
        checkOutput("t6_max_ed", sMaxEd, 16'hFFFF);
        sNumSamples = 0; sStart = 1'b1;
        @(posedge clk); #1;
        sStart = 1'b0;
        checkOutput("t6_ovf_cleared", sAccOvf, 0);
        checkOutput("t6_sum_cleared", sSumEd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
